mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory responder with a fixed access
// latency and an IDLE/BUSY/DONE request handshake.
module mem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_done,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   wr_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic [31:0]            mem_q [DEPTH];

  logic any_req;
  logic one_req;
  logic bad_addr;
  logic accept;
  logic illegal;
  logic complete;

  always_comb begin
    any_req  = mem_read | mem_write;
    one_req  = mem_read ^ mem_write;
    bad_addr = (mem_addr[1:0] != 2'b00) ||
               ((mem_addr >> (ADDR_BITS + 2)) != 32'd0);
    accept   = mem_ready && one_req && !bad_addr;
    illegal  = mem_ready && any_req && !(one_req && !bad_addr);
    complete = (state_q == BUSY) && (cnt_q == 3'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = accept ? BUSY : IDLE;
      BUSY:       if (cnt_q == 3'd0) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state_q != BUSY);
    mem_done  = (state_q == DONE);
    mem_err   = err_q;
    mem_rdata = rdata_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = illegal;
    if (accept)
      cnt_d = 3'(LATENCY - 1);
    else if (state_q == BUSY && cnt_q != 3'd0)
      cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (accept) begin
        wr_q    <= mem_write;
        idx_q   <= mem_addr[ADDR_BITS+1:2];
        wdata_q <= mem_wdata;
      end
      if (complete && !wr_q)
        rdata_q <= mem_q[idx_q];
    end
  end

  // Storage is cleared by reset, so it lives in flops, not a RAM macro
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem_q[i] <= '0;
    end else if (complete && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: transaction-level random test of mem_responder
// against an array model, plus a LATENCY=1 back-to-back instance.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready, done, err;

  logic        r1, w1;
  logic [31:0] a1, d1;
  logic [31:0] q1;
  logic        rdy1, dn1, er1;

  logic [31:0] model_mem [256];
  logic [31:0] model_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (rd),
    .mem_write (wr),
    .mem_addr  (addr),
    .mem_wdata (wdata),
    .mem_rdata (rdata),
    .mem_ready (ready),
    .mem_done  (done),
    .mem_err   (err)
  );

  mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (r1),
    .mem_write (w1),
    .mem_addr  (a1),
    .mem_wdata (d1),
    .mem_rdata (q1),
    .mem_ready (rdy1),
    .mem_done  (dn1),
    .mem_err   (er1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    model_rdata = '0;
  endtask

  task automatic idle();
    rd = 1'b0;
    wr = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_done", {31'b0, done}, 32'd0);
    chk("idle_err", {31'b0, err}, 32'd0);
    chk("idle_ready", {31'b0, ready}, 32'd1);
  endtask

  // One request from a ready state; expectations from the access rules.
  task automatic xact(input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit scr);
    bit         legal;
    int         n;
    logic [7:0] idx;
    chk("pre_ready", {31'b0, ready}, 32'd1);
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    legal = (r ^ w) && (a[1:0] == 2'b00) && ((a >> 10) == 32'd0);
    idx   = a[9:2];
    if (!(r | w)) begin
      chk("noop_err", {31'b0, err}, 32'd0);
      chk("noop_done", {31'b0, done}, 32'd0);
    end else if (!legal) begin
      rd = 1'b0;
      wr = 1'b0;
      chk("err_pulse", {31'b0, err}, 32'd1);
      chk("err_done", {31'b0, done}, 32'd0);
      chk("err_ready", {31'b0, ready}, 32'd1);
      chk("err_rdata", rdata, model_rdata);
    end else begin
      n = 0;
      while (!done && n < 16) begin
        chk("busy_ready", {31'b0, ready}, 32'd0);
        chk("busy_err", {31'b0, err}, 32'd0);
        n++;
        if (scr) begin
          rd    = 1'($urandom_range(0, 1));
          wr    = 1'($urandom_range(0, 1));
          addr  = $urandom;
          wdata = $urandom;
        end
        @(posedge clk);
        #1;
      end
      rd = 1'b0;
      wr = 1'b0;
      chk("latency", 32'(n), 32'(LAT));
      chk("done_err", {31'b0, err}, 32'd0);
      if (w) model_mem[idx] = d;
      else   model_rdata = model_mem[idx];
      chk("rdata", rdata, model_rdata);
    end
  endtask

  initial begin
    int kind;
    int t1, t2;
    logic [7:0]  idx;
    logic [31:0] cap;

    rst   = 1'b1;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    r1    = 1'b0;
    w1    = 1'b0;
    a1    = '0;
    d1    = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    xact(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
    xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    xact(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("rd_10", rdata, 32'hDEADBEEF);

    xact(1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0);
    xact(1'b1, 1'b0, 32'h402, 32'h0, 1'b0);
    xact(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
    xact(1'b1, 1'b1, 32'h10, 32'h0, 1'b0);
    xact(1'b0, 1'b1, 32'h400, 32'hBAD0_0001, 1'b0);
    xact(1'b0, 1'b1, 32'h2, 32'hBAD0_0002, 1'b0);
    xact(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rd_0_kept", rdata, 32'h1234_5678);

    xact(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b1);
    xact(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    chk("rd_latched", rdata, 32'hCAFE_F00D);

    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 9);
      idx  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      case (kind)
        0: xact(1'b0, 1'b0, {22'b0, idx, 2'b0}, $urandom, 1'b0);
        1: xact(1'($urandom_range(0, 1)), 1'b1,
                {22'b0, idx, 2'($urandom_range(1, 3))}, $urandom, 1'b0);
        2: xact(1'b1, 1'b0, ($urandom & 32'hFFFF_F000) | 32'h400 |
                {22'b0, idx, 2'b0}, $urandom, 1'b0);
        3: xact(1'b1, 1'b1, {22'b0, idx, 2'b0}, $urandom, 1'b0);
        default: xact(1'($urandom_range(0, 1)) ? 1'b1 : 1'b0, 1'b0,
                      {22'b0, idx, 2'b0}, $urandom, 1'($urandom_range(0, 1)));
      endcase
      if (kind >= 7)
        xact(1'b0, 1'b1, {22'b0, idx, 2'b0}, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle();
    end

    rd    = 1'b0;
    wr    = 1'b1;
    addr  = 32'h8;
    wdata = 32'h55;
    @(posedge clk);
    #1;
    wr = 1'b0;
    chk("abort_busy", {31'b0, ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    model_clear();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_nodone", {31'b0, done}, 32'd0);
    xact(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    chk("abort_rd8", rdata, 32'h0);
    xact(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("clear_rd10", rdata, 32'h0);

    w1 = 1'b1;
    a1 = 32'h4;
    d1 = 32'h1;
    t1 = -1;
    t2 = -1;
    cap = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (dn1) begin
        if (t1 < 0) begin
          t1 = k;
          w1 = 1'b0;
          r1 = 1'b1;
        end else if (t2 < 0) begin
          t2  = k;
          cap = q1;
          r1  = 1'b0;
        end
      end
    end
    r1 = 1'b0;
    chk("l1_first_done", 32'(t1), 32'd1);
    chk("l1_gap", 32'(t2 - t1), 32'd2);
    chk("l1_rdata", cap, 32'h1);
    chk("l1_err", {31'b0, er1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
